switch_conditioner: RTL
=======================

Name: switch_conditioner

Overview:
- Sits directly upstream of the logic under test.
- Sits between the MCPNR_SWITCHES primitive output bus and the combinational DUT (e.g. a NOR gate).
- Per switch bit, it synchronises the raw lever input, debounces it, and emits a clean level plus one-cycle rise/fall pulses.
- Downstream logic therefore sees only stable, clock-aligned inputs.

Parameters:
- NSWITCH, 2, number of switch bits conditioned in parallel (>=1).
- DEBOUNCE_CYCLES, 4, consecutive cycles a new synced value must persist before it is accepted (>=1; 0 is an elaboration error).
- CNT_W, $clog2(DEBOUNCE_CYCLES+1), counter width; derived, never overridden.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- sw_i  input  NSWITCH  raw switch levels from MCPNR_SWITCHES .O bus.
- level_o  output  NSWITCH  debounced switch level.
- rise_o  output  NSWITCH  one-cycle pulse: level_o bit went 0->1 this cycle.
- fall_o  output  NSWITCH  one-cycle pulse: level_o bit went 1->0 this cycle.

Behaviour:
- Reset (async assert, sync-style release on next edge) clears all state.
  - Cleared: sync flops, counters, level_o, rise_o, fall_o, and toggle_o if present.
  - All outputs read 0 while rst is high.
- Sync stage: two flops per bit, sw_i -> s1 -> s. Only s feeds the debouncer.
- Debouncer, per bit, each edge:
  - If s == level: cnt <= 0, no pulse.
  - If s != level and cnt < DEBOUNCE_CYCLES-1: cnt <= cnt+1, level holds.
  - If s != level and cnt == DEBOUNCE_CYCLES-1: level <= s, cnt <= 0.
    - rise_o <= s; fall_o <= !s. Both registered, asserted in the same cycle level_o first shows the new value.
  - rise_o and fall_o are 0 on every other edge. Never both high on one bit.
- Latency: sw_i stable from before edge k gives level_o changing at edge k+1+DEBOUNCE_CYCLES.
  - Example: DEBOUNCE_CYCLES=4 gives edge k+5.
  - DEBOUNCE_CYCLES=1 gives edge k+2, i.e. sync latency only.
- Glitch rejection:
  - Any excursion where s differs from level for fewer than DEBOUNCE_CYCLES consecutive edges is discarded and cnt returns to 0.
  - A partial count never carries over.
- Bits are fully independent. Simultaneous changes on several bits each follow their own counter, with no priority.
- Reset mid-count discards the partial count.
  - After release, a held-high switch produces a fresh rise after full latency.
- Counter never exceeds DEBOUNCE_CYCLES-1, so no wrap-around.

Optional Feature:
- Macro: SWITCH_CONDITIONER_TOGGLE_EN
- Defined: adds output port toggle_o [NSWITCH] (reset 0). Each bit inverts on the edge after its rise_o pulse, i.e. one cycle after rise_o.
  - Turns a momentary button into a latched on/off.
  - fall_o has no effect on toggle_o.
- Undefined: port absent, no toggle flops; all other behaviour identical.

Decomposition:
- Shared include header (mcpnr_defs.vh) holds:
  - default DEBOUNCE_CYCLES;
  - sync depth constant (2);
  - a function returning CNT_W.
- One natural sub-module: switch_debounce_bit. It is single-bit sync + counter + level/pulse regs, instantiated NSWITCH times via generate.
- Top handles bus slicing and the optional toggle flops.

Test Plan (NSWITCH=2, DEBOUNCE_CYCLES=4):
- Reset: rst=1 with sw_i=2'b11 -> level_o/rise_o/fall_o=0 throughout. Release, hold sw_i=2'b11 -> level_o=2'b11 at edge 5 after first sampling edge, rise_o=2'b11 that cycle only.
- Glitch: level 0, sw_i[0] high for 3 cycles then low -> level_o[0] stays 0, no rise_o. Repeat with 4 cycles -> level_o[0]=1 after latency.
- Fall: level_o=2'b01, drop sw_i[0] -> fall_o[0] pulses one cycle with level_o[0] going 0, rise_o=0.
- Independence: sw_i[1] rises 2 cycles after sw_i[0] -> rise_o[0] and rise_o[1] pulse 2 cycles apart, each at own latency.
- Reset mid-count: sw_i[0]=1 for 3 cycles, pulse rst -> level_o[0]=0. Keep sw_i[0]=1 -> rise after full 5-edge latency from release.
- Toggle (macro defined): three clean press/release cycles on sw_i[0] -> toggle_o[0] reads 1,0,1, each update one cycle after rise_o[0].

Source files
------------

// File: rtl/switch_conditioner_pkg.sv
// Shared constants and types for the switch conditioner: default debounce
// length, synchroniser depth, counter-width helper and the per-bit event bundle.
package switch_conditioner_pkg;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 4;
  localparam int SYNC_DEPTH              = 2;

  // Counter must hold 0..DEBOUNCE_CYCLES-1; the +1 keeps DEBOUNCE_CYCLES=1 at one bit.
  function automatic int cnt_width(input int debounce_cycles);
    return $clog2(debounce_cycles + 1);
  endfunction

  typedef struct packed {
    logic level;
    logic rise;
    logic fall;
  } sw_event_t;

endpackage

// File: rtl/switch_debounce_bit.sv
// Single switch bit: two-flop synchroniser, persistence counter, and the
// registered clean level with one-cycle rise/fall pulses.
module switch_debounce_bit
  import switch_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic sw_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int                CNT_W   = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_DEPTH-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  sw_event_t             ev_q, ev_d;
  logic                  s;

  assign sync_d = {sync_q[SYNC_DEPTH-2:0], sw_i};
  assign s      = sync_q[SYNC_DEPTH-1];

  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path can leave it unassigned and infer a latch.
    cnt_d   = '0;
    ev_d    = '{level: ev_q.level, rise: 1'b0, fall: 1'b0};
    if (s != ev_q.level) begin
      if (cnt_q == CNT_MAX) begin
        ev_d.level = s;
        ev_d.rise  = s;
        ev_d.fall  = ~s;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // NOTE: the async reset clears every flop here, synchroniser included, so a partial count or stale sample never survives reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      cnt_q  <= '0;
      ev_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so all flops update from pre-edge values, independent of statement order.
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      ev_q   <= ev_d;
    end
  end

  assign level_o = ev_q.level;
  assign rise_o  = ev_q.rise;
  assign fall_o  = ev_q.fall;

endmodule

// File: rtl/switch_conditioner.sv
// Conditions NSWITCH raw lever inputs into clean, clock-aligned levels and
// rise/fall pulses. Define SWITCH_CONDITIONER_TOGGLE_EN to add toggle_o.
module switch_conditioner
  import switch_conditioner_pkg::*;
#(
  parameter int NSWITCH         = 2,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NSWITCH-1:0] sw_i,
  output logic [NSWITCH-1:0] level_o,
  output logic [NSWITCH-1:0] rise_o,
  output logic [NSWITCH-1:0] fall_o
`ifdef SWITCH_CONDITIONER_TOGGLE_EN
  ,
  output logic [NSWITCH-1:0] toggle_o
`endif
);

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("switch_conditioner: DEBOUNCE_CYCLES must be >= 1");
  end
  if (NSWITCH < 1) begin : g_bad_nswitch
    $error("switch_conditioner: NSWITCH must be >= 1");
  end

  for (genvar i = 0; i < NSWITCH; i++) begin : g_bit
    switch_debounce_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_bit (
      .clk     (clk),
      .rst     (rst),
      .sw_i    (sw_i[i]),
      .level_o (level_o[i]),
      .rise_o  (rise_o[i]),
      .fall_o  (fall_o[i])
    );
  end

`ifdef SWITCH_CONDITIONER_TOGGLE_EN
  logic [NSWITCH-1:0] toggle_q, toggle_d;

  // Latches a momentary press: flips on the edge after each rise pulse.
  assign toggle_d = toggle_q ^ rise_o;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      toggle_q <= '0;
    end else begin
      toggle_q <= toggle_d;
    end
  end

  assign toggle_o = toggle_q;
`else
  // Momentary outputs only; no toggle state is built.
`endif

endmodule
